// File: rtl/logic_axi4_stream_packer.sv
// ---------------------------------------------------------------------------
// logic_axi4_stream_packer
//
// AXI4-Stream null-byte compactor. Bytes with tkeep=0 are dropped and the
// remaining bytes are repacked contiguously, LSB first. Every output beat is
// full except the final beat of a packet. A packet made only of null bytes
// still produces one tlast beat with tkeep=0, so the packet boundary is kept.
//
// Ports
//   aclk, areset_n          clock, asynchronous active-low reset
//   rx_t*                   AXI4-Stream slave  (tdata/tstrb/tkeep/tlast/
//                           tuser/tdest/tid, tvalid/tready)
//   tx_t*                   AXI4-Stream master (same signal set), with
//                           tkeep a low-aligned contiguous mask and
//                           tdata/tstrb zero in unused lanes
//
// Internals
//   A 2N-entry byte buffer {data, strb} plus a fill count. A tx handshake
//   shifts out min(cnt, N) bytes; an rx handshake in the same cycle appends
//   its kept bytes after the shift. Sideband is latched on the first beat of
//   each packet and held for all of its output beats.
// ---------------------------------------------------------------------------

// Per-lane output stage: a lane is live when its index is below the fill
// count (a full beat when cnt >= N); dead lanes are forced to zero.
module logic_axi4_stream_packer_lane #(
    parameter int CW   = 3,
    parameter int LANE = 0
) (
    input  logic [7:0]    data_i,
    input  logic          strb_i,
    input  logic [CW-1:0] cnt_i,
    output logic [7:0]    data_o,
    output logic          strb_o,
    output logic          keep_o
);
    assign keep_o = (cnt_i > CW'(LANE));
    assign data_o = keep_o ? data_i : 8'h00;
    assign strb_o = keep_o & strb_i;
endmodule

module logic_axi4_stream_packer #(
    parameter int TDATA_BYTES = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) (
    input  logic                     aclk,
    input  logic                     areset_n,

    input  logic                     rx_tvalid,
    output logic                     rx_tready,
    input  logic                     rx_tlast,
    input  logic [TDATA_BYTES*8-1:0] rx_tdata,
    input  logic [TDATA_BYTES-1:0]   rx_tstrb,
    input  logic [TDATA_BYTES-1:0]   rx_tkeep,
    input  logic [TUSER_WIDTH-1:0]   rx_tuser,
    input  logic [TDEST_WIDTH-1:0]   rx_tdest,
    input  logic [TID_WIDTH-1:0]     rx_tid,

    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic                     tx_tlast,
    output logic [TDATA_BYTES*8-1:0] tx_tdata,
    output logic [TDATA_BYTES-1:0]   tx_tstrb,
    output logic [TDATA_BYTES-1:0]   tx_tkeep,
    output logic [TUSER_WIDTH-1:0]   tx_tuser,
    output logic [TDEST_WIDTH-1:0]   tx_tdest,
    output logic [TID_WIDTH-1:0]     tx_tid
);
    localparam int N  = TDATA_BYTES;
    localparam int B  = 2 * N;
    localparam int CW = $clog2(B + 1);
    localparam int IW = $clog2(B);

    logic [B-1:0][7:0]      dat_q, dat_d;
    logic [B-1:0]           stb_q, stb_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   last_pend_q, last_pend_d;
    logic                   in_pkt_q, in_pkt_d;
    logic                   run_q;
    logic [TUSER_WIDTH-1:0] user_q, user_d;
    logic [TDEST_WIDTH-1:0] dest_q, dest_d;
    logic [TID_WIDTH-1:0]   id_q, id_d;

    logic          full;
    logic          tx_fire, rx_fire;
    logic [CW-1:0] sh, cnt_s, pos;
    logic [IW-1:0] idx;

    assign full      = (cnt_q >= CW'(N));
    assign tx_tvalid = full | last_pend_q;
    assign tx_tlast  = last_pend_q & (cnt_q <= CW'(N));
    assign tx_fire   = tx_tvalid & tx_tready;
    // run_q keeps rx_tready low while reset is asserted and for the first
    // edge after release. The tx_fire term lets a full buffer take a new beat
    // in the same cycle it drains, for one-beat-per-cycle throughput.
    assign rx_tready = run_q & ~last_pend_q & (~full | tx_fire);
    assign rx_fire   = rx_tvalid & rx_tready;

    assign tx_tuser = user_q;
    assign tx_tdest = dest_q;
    assign tx_tid   = id_q;

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic_axi4_stream_packer_lane #(.CW(CW), .LANE(g)) u_lane (
            .data_i (dat_q[g]),
            .strb_i (stb_q[g]),
            .cnt_i  (cnt_q),
            .data_o (tx_tdata[8*g +: 8]),
            .strb_o (tx_tstrb[g]),
            .keep_o (tx_tkeep[g])
        );
    end

    always_comb begin
        dat_d       = dat_q;
        stb_d       = stb_q;
        last_pend_d = last_pend_q;
        in_pkt_d    = in_pkt_q;
        user_d      = user_q;
        dest_d      = dest_q;
        id_d        = id_q;
        idx         = '0;

        // Drain: shift down by the number of bytes the tx beat carried.
        sh = '0;
        if (tx_fire) sh = full ? CW'(N) : cnt_q;
        for (int i = 0; i < B; i++) begin
            if (i + int'(sh) < B) begin
                idx      = IW'(i + int'(sh));
                dat_d[i] = dat_q[idx];
                stb_d[i] = stb_q[idx];
            end else begin
                dat_d[i] = 8'h00;
                stb_d[i] = 1'b0;
            end
        end
        cnt_s = cnt_q - sh;
        if (tx_fire && tx_tlast) begin
            last_pend_d = 1'b0;
            in_pkt_d    = 1'b0;
        end

        // Fill: append kept bytes in ascending lane order after the drain.
        // Acceptance rules bound cnt_s + popcount(keep) to 2N-1.
        pos = cnt_s;
        if (rx_fire) begin
            for (int j = 0; j < N; j++) begin
                if (rx_tkeep[j]) begin
                    if (pos < CW'(B)) begin
                        idx        = IW'(pos);
                        dat_d[idx] = rx_tdata[8*j +: 8];
                        stb_d[idx] = rx_tstrb[j];
                    end
                    pos = pos + CW'(1);
                end
            end
            if (rx_tlast) last_pend_d = 1'b1;
            if (!in_pkt_q) begin
                in_pkt_d = 1'b1;
                user_d   = rx_tuser;
                dest_d   = rx_tdest;
                id_d     = rx_tid;
            end
        end
        cnt_d = pos;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            dat_q       <= '0;
            stb_q       <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            run_q       <= 1'b0;
            user_q      <= '0;
            dest_q      <= '0;
            id_q        <= '0;
        end else begin
            dat_q       <= dat_d;
            stb_q       <= stb_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            in_pkt_q    <= in_pkt_d;
            run_q       <= 1'b1;
            user_q      <= user_d;
            dest_q      <= dest_d;
            id_q        <= id_d;
        end
    end
endmodule

// File: tb/tb_logic_axi4_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_logic_axi4_stream_packer
//
// Bench for the null-byte compactor (N=4). Accepted rx bytes are pushed to a
// byte-level scoreboard (with end-of-packet flag and packet sideband);
// every tx handshake pops and compares its bytes. Directed packets cover
// full streams, sparse keeps, residual tails, zero-byte packets and reset;
// a random phase adds backpressure and rx gaps.
// ---------------------------------------------------------------------------
module tb_logic_axi4_stream_packer;
    localparam int N  = 4;
    localparam int UW = 1;
    localparam int DW = 1;
    localparam int IW = 1;

    logic aclk = 1'b0;
    logic areset_n = 1'b1;
    always #5 aclk = ~aclk;

    logic            rx_tvalid, rx_tready, rx_tlast;
    logic [N*8-1:0]  rx_tdata;
    logic [N-1:0]    rx_tstrb, rx_tkeep;
    logic [UW-1:0]   rx_tuser;
    logic [DW-1:0]   rx_tdest;
    logic [IW-1:0]   rx_tid;
    logic            tx_tvalid, tx_tready, tx_tlast;
    logic [N*8-1:0]  tx_tdata;
    logic [N-1:0]    tx_tstrb, tx_tkeep;
    logic [UW-1:0]   tx_tuser;
    logic [DW-1:0]   tx_tdest;
    logic [IW-1:0]   tx_tid;

    logic_axi4_stream_packer #(
        .TDATA_BYTES(N), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW), .TID_WIDTH(IW)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
        .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep),
        .rx_tuser(rx_tuser), .rx_tdest(rx_tdest), .rx_tid(rx_tid),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb), .tx_tkeep(tx_tkeep),
        .tx_tuser(tx_tuser), .tx_tdest(tx_tdest), .tx_tid(tx_tid)
    );

    typedef struct {
        logic [N*8-1:0] data;
        logic [N-1:0]   strb;
        logic [N-1:0]   keep;
        logic           last;
        logic [UW-1:0]  user;
        logic [DW-1:0]  dest;
        logic [IW-1:0]  id;
    } rxb_t;

    typedef struct {
        logic [7:0]    d;
        logic          s;
        logic          last;
        logic          empty;
        logic [UW-1:0] u;
        logic [DW-1:0] de;
        logic [IW-1:0] id;
    } exb_t;

    rxb_t stim_q[$];
    exb_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_beats, first_cyc, last_cyc;
    int tready_pct = 100;
    int gap_pct = 0;
    logic rx_fired = 1'b0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_snap;
    logic [N*8-1:0] cap_data;
    logic [N-1:0]   cap_keep, cap_strb;
    logic           cap_last;
    logic [2:0]     cap_side;

    logic          m_in_pkt = 1'b0;
    int            m_bytes = 0;
    logic [UW-1:0] m_user;
    logic [DW-1:0] m_dest;
    logic [IW-1:0] m_id;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return 64'({tx_tvalid, tx_tlast, tx_tdata, tx_tstrb, tx_tkeep, tx_tuser, tx_tdest, tx_tid});
    endfunction

    task automatic add_beat(input logic [N*8-1:0] d, input logic [N-1:0] s, input logic [N-1:0] k,
                            input logic l, input logic [2:0] side);
        rxb_t b;
        b.data = d; b.strb = s; b.keep = k; b.last = l;
        b.user = side[2]; b.dest = side[1]; b.id = side[0];
        stim_q.push_back(b);
    endtask

    // Reference model of what an accepted rx beat contributes to the output.
    task automatic push_exp(input rxb_t b);
        exb_t e;
        int hi = -1;
        for (int j = 0; j < N; j++) if (b.keep[j]) hi = j;
        if (!m_in_pkt) begin
            m_user = b.user; m_dest = b.dest; m_id = b.id;
            m_in_pkt = 1'b1; m_bytes = 0;
        end
        for (int j = 0; j < N; j++) begin
            if (b.keep[j]) begin
                e.d = b.data[8*j +: 8]; e.s = b.strb[j];
                e.last = b.last && (j == hi); e.empty = 1'b0;
                e.u = m_user; e.de = m_dest; e.id = m_id;
                sb_q.push_back(e);
                m_bytes++;
            end
        end
        if (b.last) begin
            if (m_bytes == 0) begin
                e.d = 8'h00; e.s = 1'b0; e.last = 1'b1; e.empty = 1'b1;
                e.u = m_user; e.de = m_dest; e.id = m_id;
                sb_q.push_back(e);
            end
            m_in_pkt = 1'b0;
        end
    endtask

    task automatic check_tx();
        exb_t e;
        int k;
        logic lastf, midl;
        logic [N-1:0] msk;
        logic [N*8-1:0] dmsk;
        tx_beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        cap_data = tx_tdata; cap_keep = tx_tkeep; cap_strb = tx_tstrb;
        cap_last = tx_tlast; cap_side = {tx_tuser, tx_tdest, tx_tid};
        k = $countones(tx_tkeep);
        msk = N'((1 << k) - 1);
        dmsk = '0;
        for (int i = 0; i < N; i++) if (msk[i]) dmsk[8*i +: 8] = 8'hFF;
        chk("keep_contig", 64'(tx_tkeep), 64'(msk));
        chk("unused_zero", 64'({tx_tdata & ~dmsk, tx_tstrb & ~msk}), 64'(0));
        chk("full_or_last", 64'((tx_tkeep == {N{1'b1}}) || tx_tlast), 64'(1));
        e.u = '0; e.de = '0; e.id = '0;
        if (k == 0) begin
            if (sb_q.size() == 0) chk("sb_underflow", 64'(0), 64'(1));
            else begin
                e = sb_q.pop_front();
                chk("empty_pkt", 64'(e.empty), 64'(1));
                chk("tlast", 64'(tx_tlast), 64'(1));
                chk("side", 64'({tx_tuser, tx_tdest, tx_tid}), 64'({e.u, e.de, e.id}));
            end
        end else begin
            lastf = 1'b0; midl = 1'b0;
            for (int i = 0; i < k; i++) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(0), 64'(1));
                    break;
                end
                e = sb_q.pop_front();
                midl |= lastf;
                lastf = e.last;
                chk("data", 64'(tx_tdata[8*i +: 8]), 64'(e.d));
                chk("strb", 64'(tx_tstrb[i]), 64'(e.s));
                chk("not_empty", 64'(e.empty), 64'(0));
            end
            chk("tlast", 64'(tx_tlast), 64'(lastf));
            chk("mid_last", 64'(midl), 64'(0));
            chk("side", 64'({tx_tuser, tx_tdest, tx_tid}), 64'({e.u, e.de, e.id}));
        end
    endtask

    // One cycle: drive at the falling edge, settle, then evaluate the
    // handshakes that the next rising edge will perform.
    task automatic step();
        rxb_t b;
        @(negedge aclk);
        cyc++;
        if (rx_fired || !rx_tvalid) begin
            if (stim_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                b = stim_q[0];
                rx_tvalid = 1'b1; rx_tdata = b.data; rx_tstrb = b.strb; rx_tkeep = b.keep;
                rx_tlast = b.last; rx_tuser = b.user; rx_tdest = b.dest; rx_tid = b.id;
            end else begin
                rx_tvalid = 1'b0;
            end
        end
        tx_tready = ($urandom_range(0, 99) < tready_pct);
        #1;
        if (prev_stall) chk("stable", snap(), prev_snap);
        prev_stall = tx_tvalid && !tx_tready;
        prev_snap = snap();
        if (tx_tvalid && tx_tready) check_tx();
        rx_fired = rx_tvalid && rx_tready;
        if (rx_fired) begin
            b = stim_q.pop_front();
            push_exp(b);
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0 || tx_tvalid) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(n < budget), 64'(1));
    endtask

    task automatic clr_stats();
        tx_beats = 0; first_cyc = -1; last_cyc = -1;
    endtask

    initial begin
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0; rx_tstrb = '0; rx_tkeep = '0;
        rx_tuser = '0; rx_tdest = '0; rx_tid = '0; tx_tready = 1'b0;
        clr_stats();
        #1 areset_n = 1'b0;
        #2;
        chk("rst_tvalid", 64'(tx_tvalid), 64'(0));
        chk("rst_rready", 64'(rx_tready), 64'(0));
        chk("rst_out", 64'({tx_tlast, tx_tdata, tx_tstrb, tx_tkeep, tx_tuser, tx_tdest, tx_tid}), 64'(0));
        repeat (3) @(negedge aclk);
        areset_n = 1'b1;
        step();

        // Full-keep back-to-back stream: one tx beat per cycle.
        clr_stats();
        for (int i = 0; i < 8; i++) add_beat(32'hA0B0C0D0 ^ 32'(i * 32'h01010101), 4'hF, 4'hF, i == 7, 3'b101);
        run_idle(100);
        chk("t1_beats", 64'(tx_beats), 64'(8));
        chk("t1_spacing", 64'(last_cyc - first_cyc), 64'(7));
        chk("t1_last", 64'(cap_last), 64'(1));

        // Sparse keep: lanes 0,2 (11,33) then lanes 1,3 (66,88) -> 0x88663311.
        clr_stats();
        add_beat(32'h44332211, 4'hF, 4'b0101, 1'b0, 3'b010);
        add_beat(32'h88776655, 4'hF, 4'b1010, 1'b1, 3'b000);
        run_idle(100);
        chk("t2_beats", 64'(tx_beats), 64'(1));
        chk("t2_data", 64'(cap_data), 64'(32'h88663311));
        chk("t2_keep", 64'(cap_keep), 64'(4'hF));
        chk("t2_last", 64'(cap_last), 64'(1));
        chk("t2_side", 64'(cap_side), 64'(3'b010));

        // Sparse keep on the even lanes of both beats -> 0x77553311.
        clr_stats();
        add_beat(32'h44332211, 4'hF, 4'b0101, 1'b0, 3'b000);
        add_beat(32'h88776655, 4'hF, 4'b0101, 1'b1, 3'b000);
        run_idle(100);
        chk("t2b_data", 64'(cap_data), 64'(32'h77553311));

        // Residual tail: 9 bytes -> F, F, 1.
        clr_stats();
        for (int i = 0; i < 3; i++) add_beat(32'h00302010 + 32'(i * 3), 4'b0101, 4'b0111, i == 2, 3'b000);
        run_idle(100);
        chk("t3_beats", 64'(tx_beats), 64'(3));
        chk("t3_keep", 64'(cap_keep), 64'(4'b0001));
        chk("t3_last", 64'(cap_last), 64'(1));

        // Zero-byte packet.
        clr_stats();
        add_beat(32'hDEADBEEF, 4'hF, 4'h0, 1'b1, 3'b111);
        run_idle(100);
        chk("t4_beats", 64'(tx_beats), 64'(1));
        chk("t4_keep", 64'(cap_keep), 64'(0));
        chk("t4_strb", 64'(cap_strb), 64'(0));
        chk("t4_last", 64'(cap_last), 64'(1));
        chk("t4_side", 64'(cap_side), 64'(3'b111));

        // Reset with 5 bytes buffered.
        tready_pct = 0;
        add_beat(32'h33221100, 4'hF, 4'b0111, 1'b0, 3'b000);
        add_beat(32'h77665544, 4'hF, 4'b0011, 1'b0, 3'b000);
        for (int n = 0; n < 20 && stim_q.size() > 0; n++) step();
        step();
        chk("t5_fill", 64'({tx_tvalid, tx_tkeep, tx_tlast}), 64'({1'b1, 4'hF, 1'b0}));
        @(negedge aclk);
        areset_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(tx_tvalid), 64'(0));
        chk("t5_rst_rready", 64'(rx_tready), 64'(0));
        stim_q.delete(); sb_q.delete();
        m_in_pkt = 1'b0; m_bytes = 0;
        rx_tvalid = 1'b0; rx_fired = 1'b0; prev_stall = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        tready_pct = 100;
        clr_stats();
        add_beat(32'hC3C2C1C0, 4'hF, 4'hF, 1'b0, 3'b011);
        add_beat(32'hC7C6C5C4, 4'hF, 4'hF, 1'b1, 3'b000);
        run_idle(100);
        chk("t5_beats", 64'(tx_beats), 64'(2));
        chk("t5_data", 64'(cap_data), 64'(32'hC7C6C5C4));

        // Random keep, sideband, gaps and 30% downstream ready.
        tready_pct = 30;
        gap_pct = 20;
        for (int p = 0; p < 200; p++) begin
            logic [2:0] side;
            int nb;
            side = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                add_beat($urandom, 4'($urandom), 4'h0, 1'b1, side);
            end else begin
                nb = $urandom_range(1, 5);
                for (int i = 0; i < nb; i++) begin
                    logic [N-1:0] k;
                    k = 4'($urandom_range(0, 15));
                    if (i == nb - 1 && k == 0) k = 4'(1 << $urandom_range(0, 3));
                    // Later beats carry different sideband, which must be ignored.
                    add_beat($urandom, 4'($urandom), k, i == nb - 1, (i == 0) ? side : 3'($urandom));
                end
            end
        end
        run_idle(20000);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
